// File: rtl/fv_bank_req_arbiter_pkg.sv
// Shared types and sizing for the feature-value bank request arbiter.
// Widths derive from the project-wide Num_Edge_PE / Max_Node_id / FV_bandwidth macros.
`ifndef Num_Edge_PE
`define Num_Edge_PE 4
`endif
`ifndef Max_Node_id
`define Max_Node_id 256
`endif
`ifndef FV_bandwidth
`define FV_bandwidth 64
`endif

package fv_bank_req_arbiter_pkg;

  localparam int FV_NUM_PE    = `Num_Edge_PE;
  localparam int FV_NODE_ID_W = $clog2(`Max_Node_id);
  localparam int FV_DATA_W    = `FV_bandwidth;
  localparam int FV_TAG_W     = (FV_NUM_PE > 1) ? $clog2(FV_NUM_PE) : 1;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WB_STREAM = 2'd1,
    ST_HOLD      = 2'd2,
    ST_WAIT_DONE = 2'd3
  } arb_state_e;

  typedef struct packed {
    logic                    valid;
    logic                    rd_wr;
    logic [FV_NODE_ID_W-1:0] Node_id;
    logic [FV_TAG_W-1:0]     PE_tag;
    logic [FV_DATA_W-1:0]    data;
    logic                    wr_eos;
  } Req2Output_SRAM_Bank;

  // Position reached by stepping b places from a on a ring of n slots.
  function automatic int ring_pos(input int a, input int b, input int n);
    return (a + b) % n;
  endfunction

endpackage

// File: rtl/fv_bank_req_arbiter_chk.sv
// Simulation-only protocol checks for the bank request arbiter.
module fv_bank_req_arbiter_chk #(
  parameter int NUM_PE = 4
) (
  input logic              clk,
  input logic              reset,
  input logic              i_in_stream,
  input logic              i_wb_valid,
  input logic              i_req_valid,
  input logic              i_req_rd_wr,
  input logic [NUM_PE-1:0] i_ack
);

  // The bank swallows one line per cycle, so a stream may not stall.
  a_stream_no_gap: assert property (@(posedge clk) disable iff (reset) i_in_stream |-> i_wb_valid);
  a_ack_onehot:    assert property (@(posedge clk) disable iff (reset) $onehot0(i_ack));
  a_ack_is_read:   assert property (@(posedge clk) disable iff (reset) (|i_ack) |-> (i_req_valid && !i_req_rd_wr));

endmodule

// File: rtl/fv_bank_req_arbiter_rr_pick.sv
// Combinational round-robin finder: first set request at or after the pointer, wrapping.
module fv_bank_req_arbiter_rr_pick
  import fv_bank_req_arbiter_pkg::*;
#(
  parameter int NUM_PE = 4,
  parameter int TAG_W  = 2
) (
  input  logic [NUM_PE-1:0] i_req,
  input  logic [TAG_W-1:0]  i_ptr,
  output logic [NUM_PE-1:0] o_grant,
  output logic [TAG_W-1:0]  o_idx,
  output logic              o_found
);

  int             w_pos;
  logic [TAG_W-1:0] w_sel;
  logic           w_hit;

  // Scan from farthest to nearest so the nearest hit is the one that sticks.
  always_comb begin
    o_idx   = {TAG_W{1'b0}};
    o_found = 1'b0;
    w_pos   = 0;
    w_sel   = {TAG_W{1'b0}};
    w_hit   = 1'b0;
    for (int k = NUM_PE - 1; k >= 0; k--) begin
      w_pos   = ring_pos(int'(i_ptr), k, NUM_PE);
      w_sel   = TAG_W'(w_pos);
      w_hit   = i_req[w_sel];
      o_idx   = w_hit ? w_sel : o_idx;
      o_found = o_found | w_hit;
    end
    o_grant = o_found ? (NUM_PE'(1'b1) << o_idx) : {NUM_PE{1'b0}};
  end

endmodule

// File: rtl/fv_bank_req_arbiter.sv
// Request arbiter in front of one feature-value bank: write-back stream beats round-robin PE reads.
// Optional FV_ARB_PERF_CNT_EN adds saturating grant/stream/stall counters.
module fv_bank_req_arbiter
  import fv_bank_req_arbiter_pkg::*;
#(
  parameter int NUM_PE    = FV_NUM_PE,
  parameter int NODE_ID_W = FV_NODE_ID_W,
  parameter int DATA_W    = FV_DATA_W,
  parameter int TAG_W     = (NUM_PE > 1) ? $clog2(NUM_PE) : 1
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        bank_available,
  input  logic [NUM_PE-1:0]           pe_rd_req,
  input  logic [NUM_PE*NODE_ID_W-1:0] pe_rd_nodeid,
  output logic [NUM_PE-1:0]           pe_rd_ack,
  input  logic                        wb_valid,
  input  logic [NODE_ID_W-1:0]        wb_nodeid,
  input  logic [DATA_W-1:0]           wb_data,
  input  logic                        wb_eos,
  output logic                        wb_ready,
  output logic                        req_valid,
  output logic                        req_rd_wr,
  output logic [NODE_ID_W-1:0]        req_node_id,
  output logic [TAG_W-1:0]            req_pe_tag,
  output logic [DATA_W-1:0]           req_data,
  output logic                        req_wr_eos
`ifdef FV_ARB_PERF_CNT_EN
  ,
  output logic [31:0]                 perf_rd_grants,
  output logic [31:0]                 perf_wb_streams,
  output logic [31:0]                 perf_stall_cycles
`endif
);

  arb_state_e       r_state;
  logic [TAG_W-1:0] r_rr_ptr;

  logic [NUM_PE-1:0]    w_grant;
  logic [TAG_W-1:0]     w_idx;
  logic                 w_found;
  logic                 w_wb_issue;
  logic                 w_rd_issue;
  logic [NODE_ID_W-1:0] w_rd_node;
  logic                 w_in_stream;

  fv_bank_req_arbiter_rr_pick #(.NUM_PE(NUM_PE), .TAG_W(TAG_W)) u_rr_pick (
    .i_req   (pe_rd_req),
    .i_ptr   (r_rr_ptr),
    .o_grant (w_grant),
    .o_idx   (w_idx),
    .o_found (w_found)
  );

  // Reset forces every output low asynchronously, not just the state.
  always_comb begin
    w_wb_issue = 1'b0;
    w_rd_issue = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_wb_issue = ~reset & bank_available & wb_valid;
        w_rd_issue = ~reset & bank_available & ~wb_valid & w_found;
      end
      ST_WB_STREAM: w_wb_issue = ~reset & wb_valid;
      default: begin
        w_wb_issue = 1'b0;
        w_rd_issue = 1'b0;
      end
    endcase
  end

  always_comb begin
    w_rd_node = {NODE_ID_W{1'b0}};
    for (int i = 0; i < NUM_PE; i++) begin
      w_rd_node = w_rd_node | ({NODE_ID_W{w_grant[i]}} & pe_rd_nodeid[i*NODE_ID_W +: NODE_ID_W]);
    end
  end

  always_comb begin
    req_valid   = w_wb_issue | w_rd_issue;
    req_rd_wr   = w_wb_issue;
    req_node_id = w_wb_issue ? wb_nodeid : (w_rd_issue ? w_rd_node : {NODE_ID_W{1'b0}});
    req_pe_tag  = w_rd_issue ? w_idx : {TAG_W{1'b0}};
    req_data    = w_wb_issue ? wb_data : {DATA_W{1'b0}};
    req_wr_eos  = w_wb_issue & wb_eos;
    wb_ready    = w_wb_issue;
    pe_rd_ack   = w_rd_issue ? w_grant : {NUM_PE{1'b0}};
  end

  // HOLD masks the bank's stale available flag for the cycle right after an issue.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= ST_IDLE;
      r_rr_ptr <= {TAG_W{1'b0}};
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_wb_issue) begin
            r_state <= wb_eos ? ST_HOLD : ST_WB_STREAM;
          end else if (w_rd_issue) begin
            r_state  <= ST_HOLD;
            r_rr_ptr <= (w_idx == TAG_W'(NUM_PE - 1)) ? {TAG_W{1'b0}} : (w_idx + TAG_W'(1));
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_WB_STREAM: r_state <= (w_wb_issue && wb_eos) ? ST_HOLD : ST_WB_STREAM;
        ST_HOLD:      r_state <= ST_WAIT_DONE;
        ST_WAIT_DONE: r_state <= bank_available ? ST_IDLE : ST_WAIT_DONE;
        default:      r_state <= ST_IDLE;
      endcase
    end
  end

  assign w_in_stream = (r_state == ST_WB_STREAM);

  fv_bank_req_arbiter_chk #(.NUM_PE(NUM_PE)) u_chk (
    .clk         (clk),
    .reset       (reset),
    .i_in_stream (w_in_stream),
    .i_wb_valid  (wb_valid),
    .i_req_valid (req_valid),
    .i_req_rd_wr (req_rd_wr),
    .i_ack       (pe_rd_ack)
  );

`ifdef FV_ARB_PERF_CNT_EN
  logic w_stall;
  logic w_wb_start;

  assign w_stall    = ((|pe_rd_req) | wb_valid) & ~req_valid;
  assign w_wb_start = w_wb_issue & (r_state == ST_IDLE);

  // Counters stick at all-ones rather than wrapping.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_rd_grants    <= 32'd0;
      perf_wb_streams   <= 32'd0;
      perf_stall_cycles <= 32'd0;
    end else begin
      if (w_rd_issue && (perf_rd_grants != 32'hFFFF_FFFF)) perf_rd_grants <= perf_rd_grants + 32'd1;
      else perf_rd_grants <= perf_rd_grants;
      if (w_wb_start && (perf_wb_streams != 32'hFFFF_FFFF)) perf_wb_streams <= perf_wb_streams + 32'd1;
      else perf_wb_streams <= perf_wb_streams;
      if (w_stall && (perf_stall_cycles != 32'hFFFF_FFFF)) perf_stall_cycles <= perf_stall_cycles + 32'd1;
      else perf_stall_cycles <= perf_stall_cycles;
    end
  end
`endif

endmodule

// File: tb/tb_fv_bank_req_arbiter.sv
// Directed bench for fv_bank_req_arbiter with a per-cycle behavioural reference model.
module tb_fv_bank_req_arbiter;

  localparam int NUM_PE    = 4;
  localparam int NODE_ID_W = 8;
  localparam int DATA_W    = 64;
  localparam int TAG_W     = 2;

  logic                        clk = 1'b0;
  logic                        reset = 1'b1;
  logic                        bank_available = 1'b1;
  logic [NUM_PE-1:0]           pe_rd_req = 4'b0000;
  logic [NUM_PE*NODE_ID_W-1:0] pe_rd_nodeid = {8'h40, 8'h30, 8'h20, 8'h10};
  logic [NUM_PE-1:0]           pe_rd_ack;
  logic                        wb_valid = 1'b0;
  logic [NODE_ID_W-1:0]        wb_nodeid = 8'h00;
  logic [DATA_W-1:0]           wb_data = 64'h0;
  logic                        wb_eos = 1'b0;
  logic                        wb_ready;
  logic                        req_valid;
  logic                        req_rd_wr;
  logic [NODE_ID_W-1:0]        req_node_id;
  logic [TAG_W-1:0]            req_pe_tag;
  logic [DATA_W-1:0]           req_data;
  logic                        req_wr_eos;
`ifdef FV_ARB_PERF_CNT_EN
  logic [31:0] perf_rd_grants, perf_wb_streams, perf_stall_cycles;
`endif

  always #5 clk = ~clk;

  fv_bank_req_arbiter dut (
    .clk            (clk),
    .reset          (reset),
    .bank_available (bank_available),
    .pe_rd_req      (pe_rd_req),
    .pe_rd_nodeid   (pe_rd_nodeid),
    .pe_rd_ack      (pe_rd_ack),
    .wb_valid       (wb_valid),
    .wb_nodeid      (wb_nodeid),
    .wb_data        (wb_data),
    .wb_eos         (wb_eos),
    .wb_ready       (wb_ready),
    .req_valid      (req_valid),
    .req_rd_wr      (req_rd_wr),
    .req_node_id    (req_node_id),
    .req_pe_tag     (req_pe_tag),
    .req_data       (req_data),
    .req_wr_eos     (req_wr_eos)
`ifdef FV_ARB_PERF_CNT_EN
    ,
    .perf_rd_grants    (perf_rd_grants),
    .perf_wb_streams   (perf_wb_streams),
    .perf_stall_cycles (perf_stall_cycles)
`endif
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Reference model: ring pointer plus "blocked" bookkeeping.
  int m_ptr = 0;
  bit m_stream = 1'b0;
  bit m_skip = 1'b0;
  bit m_wait = 1'b0;
  int m_rd_cnt = 0;
  int m_wb_cnt = 0;
  int m_stall_cnt = 0;

  typedef struct {
    int         cyc;
    logic       rd_wr;
    logic [1:0] tag;
    logic [7:0] node;
    logic [63:0] data;
    logic       eos;
  } ev_t;
  ev_t log_q[$];

  // Stimulus-side bank and stream state.
  bit rearm = 1'b0;
  bit bank_off = 1'b0;
  int busy_len = 0;
  int bank_cnt = 0;
  int wb_len = 0;
  int wb_pos = 0;

  initial begin : compare
    bit          e_wb, e_rd;
    int          g, idx;
    logic [81:0] exp_v, got_v;
    logic [7:0]  e_node;
    forever begin
      @(negedge clk);
      cyc++;
      e_wb = 1'b0;
      e_rd = 1'b0;
      g = -1;
      if (!reset) begin
        if (m_stream) begin
          e_wb = wb_valid;
        end else if (!m_skip && !m_wait && bank_available) begin
          if (wb_valid) begin
            e_wb = 1'b1;
          end else begin
            for (int k = 0; k < NUM_PE; k++) begin
              idx = (m_ptr + k) % NUM_PE;
              if (g < 0 && (((pe_rd_req >> idx) & 4'b0001) != 4'b0000)) g = idx;
            end
            e_rd = (g >= 0);
          end
        end
      end
      e_node = e_wb ? wb_nodeid : (e_rd ? 8'(pe_rd_nodeid >> (g * 8)) : 8'h00);
      exp_v = {e_wb | e_rd, e_wb, e_node, (e_rd ? 2'(g) : 2'b00), (e_wb ? wb_data : 64'h0),
               e_wb & wb_eos, e_wb, (e_rd ? (4'b0001 << g) : 4'b0000)};
      got_v = {req_valid, req_rd_wr, req_node_id, req_pe_tag, req_data, req_wr_eos, wb_ready, pe_rd_ack};
      checks++;
      if (got_v !== exp_v) begin
        errors++;
        $display("FAIL cycle_outputs cyc=%0d got=%h exp=%h", cyc, got_v, exp_v);
      end
      if (!reset && req_valid)
        log_q.push_back('{cyc, req_rd_wr, req_pe_tag, req_node_id, req_data, req_wr_eos});
      if (reset) begin
        m_ptr = 0; m_stream = 1'b0; m_skip = 1'b0; m_wait = 1'b0;
        m_rd_cnt = 0; m_wb_cnt = 0; m_stall_cnt = 0;
      end else begin
        if (((|pe_rd_req) || wb_valid) && !(e_wb || e_rd)) m_stall_cnt++;
        if (m_stream) begin
          if (e_wb && wb_eos) begin m_stream = 1'b0; m_skip = 1'b1; end
        end else if (m_skip) begin
          m_skip = 1'b0; m_wait = 1'b1;
        end else if (m_wait) begin
          if (bank_available) m_wait = 1'b0;
        end else if (e_wb) begin
          m_wb_cnt++;
          if (wb_eos) m_skip = 1'b1; else m_stream = 1'b1;
        end else if (e_rd) begin
          m_rd_cnt++;
          m_ptr = (g + 1) % NUM_PE;
          m_skip = 1'b1;
        end
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  // One clock: sample handshakes just before the edge, then drive PEs, stream and bank after it.
  task automatic step();
    logic [NUM_PE-1:0] ack_s;
    logic rdy_s, cmpl_s;
    @(negedge clk);
    #3;
    ack_s  = pe_rd_ack;
    rdy_s  = wb_ready;
    cmpl_s = req_valid && (!req_rd_wr || req_wr_eos);
    @(posedge clk);
    #1;
    if (!rearm) pe_rd_req = pe_rd_req & ~ack_s;
    if (rdy_s && wb_len > 0) begin
      wb_pos++;
      if (wb_pos >= wb_len) begin
        wb_valid = 1'b0; wb_eos = 1'b0; wb_len = 0;
      end else begin
        wb_data = 64'hD000_0000_0000_0000 | 64'(wb_pos);
        wb_eos  = (wb_pos == wb_len - 1);
      end
    end
    if (cmpl_s) bank_cnt = busy_len + 1;
    if (bank_cnt > 0) begin
      bank_available = (bank_cnt == busy_len + 1);
      bank_cnt--;
    end else begin
      bank_available = !bank_off;
    end
  endtask

  task automatic start_wb(input logic [7:0] node, input int len);
    wb_nodeid = node;
    wb_len    = len;
    wb_pos    = 0;
    wb_data   = 64'hD000_0000_0000_0000;
    wb_eos    = (len == 1);
    wb_valid  = 1'b1;
  endtask

  task automatic wait_log(input int n, input int bound, input string name);
    int k = 0;
    while (log_q.size() < n && k < bound) begin
      step();
      k++;
    end
    checks++;
    if (log_q.size() < n) begin
      errors++;
      $display("FAIL %s timeout got=%0d exp=%0d", name, log_q.size(), n);
    end
  endtask

  initial begin : main
    logic [9:0] tags;
    // Reset must dominate even with every request pending.
    wb_valid  = 1'b1;
    pe_rd_req = 4'b1111;
    #12;
    chk("reset_outputs", {req_valid, req_rd_wr, wb_ready, req_wr_eos, pe_rd_ack, req_node_id, req_pe_tag}, 64'd0);
    chk("reset_data", req_data, 64'd0);
    @(posedge clk);
    #1;
    wb_valid  = 1'b0;
    reset     = 1'b0;

    // Two PE reads, minimum spacing with an instantly-free bank.
    busy_len  = 0;
    pe_rd_req = 4'b0101;
    log_q.delete();
    wait_log(2, 30, "t1_reads");
    chk("t1_first_tag", {62'd0, log_q[0].tag}, 64'd0);
    chk("t1_first_node", {56'd0, log_q[0].node}, 64'h10);
    chk("t1_first_rdwr", {63'd0, log_q[0].rd_wr}, 64'd0);
    chk("t1_second_tag", {62'd0, log_q[1].tag}, 64'd2);
    chk("t1_second_node", {56'd0, log_q[1].node}, 64'h30);
    chk("t1_spacing", 64'(log_q[1].cyc - log_q[0].cyc), 64'd3);
    repeat (6) step();

    // Four-line write-back beats a simultaneous PE1 read.
    busy_len = 3;
    log_q.delete();
    start_wb(8'h24, 4);
    pe_rd_req[1] = 1'b1;
    wait_log(5, 40, "t2_wb_then_read");
    chk("t2_wr_flags", {60'd0, log_q[3].rd_wr, log_q[2].rd_wr, log_q[1].rd_wr, log_q[0].rd_wr}, 64'hF);
    chk("t2_eos_pattern", {60'd0, log_q[3].eos, log_q[2].eos, log_q[1].eos, log_q[0].eos}, 64'h8);
    chk("t2_wr_node", {56'd0, log_q[2].node}, 64'h24);
    chk("t2_line1_data", log_q[1].data, 64'hD000_0000_0000_0001);
    chk("t2_back_to_back", 64'(log_q[3].cyc - log_q[0].cyc), 64'd3);
    chk("t2_read_tag", {61'd0, log_q[4].rd_wr, log_q[4].tag}, 64'd1);
    chk("t2_read_node", {56'd0, log_q[4].node}, 64'h20);
    chk("t2_read_gap", 64'(log_q[4].cyc - log_q[3].cyc), 64'd6);
    repeat (10) step();

    // Single-line write-back.
    log_q.delete();
    start_wb(8'h55, 1);
    wait_log(1, 20, "t3_single");
    repeat (8) step();
    chk("t3_count", 64'(log_q.size()), 64'd1);
    chk("t3_eos_wr_node", {54'd0, log_q[0].eos, log_q[0].rd_wr, log_q[0].node}, {54'd0, 2'b11, 8'h55});

    // Bank unavailable with every PE requesting, then round-robin order from a fresh reset.
    reset = 1'b1;
    bank_cnt = 0;
    step();
    reset = 1'b0;
    busy_len = 1;
    bank_off = 1'b1;
    bank_available = 1'b0;
    pe_rd_req = 4'b1111;
    rearm = 1'b1;
    log_q.delete();
    repeat (10) step();
    chk("t4_blocked", 64'(log_q.size()), 64'd0);
    bank_off = 1'b0;
    bank_available = 1'b1;
    wait_log(5, 60, "t4_rr");
    rearm = 1'b0;
    pe_rd_req = 4'b0000;
    tags = {log_q[4].tag, log_q[3].tag, log_q[2].tag, log_q[1].tag, log_q[0].tag};
    chk("t4_rr_order", {54'd0, tags}, {54'd0, 10'b00_11_10_01_00});
    repeat (10) step();

    // Async reset during line 2 of a stream.
    log_q.delete();
    start_wb(8'h77, 4);
    wait_log(1, 20, "t5_line1");
    #2;
    chk("t5_line2_live", {63'd0, req_valid}, 64'd1);
    reset = 1'b1;
    #1;
    chk("t5_async_clear", {60'd0, req_valid, wb_ready, req_rd_wr, req_wr_eos}, 64'd0);
    wb_valid = 1'b0; wb_eos = 1'b0; wb_len = 0; bank_cnt = 0; bank_available = 1'b1;
    step();
    reset = 1'b0;
    pe_rd_req = 4'b1001;
    log_q.delete();
    wait_log(2, 20, "t5_after_reset");
    chk("t5_ptr_zero_tag", {62'd0, log_q[0].tag}, 64'd0);
    chk("t5_first_node", {56'd0, log_q[0].node}, 64'h10);
    chk("t5_second_tag", {62'd0, log_q[1].tag}, 64'd3);
    repeat (6) step();

`ifdef FV_ARB_PERF_CNT_EN
    chk("perf_rd", {32'd0, perf_rd_grants}, 64'(m_rd_cnt));
    chk("perf_wb", {32'd0, perf_wb_streams}, 64'(m_wb_cnt));
    chk("perf_stall", {32'd0, perf_stall_cycles}, 64'(m_stall_cnt));
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fv_bank_req_arbiter.md
Name: fv_bank_req_arbiter

Overview:
- Sits directly upstream of one feature-value bank controller and produces that controller's single request packet (valid, rd_wr, Node_id, PE_tag, data, wr_eos).
- Arbitrates between NUM_PE Edge PE read requests and one write-back stream from the accumulate/vertex buffer.
- Issues a request only when the bank reports available, then holds off until the bank has left and re-entered IDLE.

Parameters:
- NUM_PE, 4, number of Edge PE read requesters (`Num_Edge_PE).
- NODE_ID_W, 8, node id width (clog2 `Max_Node_id).
- DATA_W, 64, feature-value line width (`FV_bandwidth).
- TAG_W, clog2(NUM_PE), PE tag width.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- bank_available  in  1  bank controller is in IDLE.
- pe_rd_req  in  NUM_PE  per-PE read request, level, held until acked.
- pe_rd_nodeid  in  NUM_PE*NODE_ID_W  per-PE node id; PE i occupies slice i.
- pe_rd_ack  out  NUM_PE  one-cycle pulse when PE i's request is issued.
- wb_valid  in  1  write-back line valid.
- wb_nodeid  in  NODE_ID_W  node being written back; constant across one stream.
- wb_data  in  DATA_W  write-back line.
- wb_eos  in  1  last line of the write-back stream.
- wb_ready  out  1  write-back line accepted this cycle.
- req_valid  out  1  request packet valid.
- req_rd_wr  out  1  1 = write back, 0 = Edge PE read.
- req_node_id  out  NODE_ID_W  node id.
- req_pe_tag  out  TAG_W  requesting PE index; 0 for writes.
- req_data  out  DATA_W  write data; 0 for reads.
- req_wr_eos  out  1  last write line.

Behaviour:
- Request outputs are combinational from state plus inputs; the bank registers them.
- States: IDLE, WB_STREAM, HOLD, WAIT_DONE. Reset (async) -> IDLE, rr_ptr = 0.
- Every output is 0 when in reset and in any cycle with no issue or transfer.
- IDLE, bank_available=1, wb_valid=1 (write back has priority over all reads):
  - Drive req_valid=1, req_rd_wr=1, req_node_id=wb_nodeid, req_data=wb_data, req_wr_eos=wb_eos; wb_ready=1.
  - Next state is HOLD if wb_eos=1, otherwise WB_STREAM.
- IDLE, bank_available=1, wb_valid=0, some pe_rd_req set:
  - Grant the first set bit at or after rr_ptr, wrapping modulo NUM_PE.
  - Drive req_valid=1, req_rd_wr=0, req_node_id=the granted slice, req_pe_tag=grant index; pulse pe_rd_ack[grant].
  - rr_ptr <= (grant+1) mod NUM_PE. Next state HOLD.
- IDLE, bank_available=0: issue nothing and stay in IDLE.
- WB_STREAM: the bank consumes one line per cycle, so the source must present wb_valid=1 every cycle until eos.
  - Each cycle drive req_valid=1, req_rd_wr=1, req_node_id=wb_nodeid, req_data=wb_data, req_wr_eos=wb_eos; wb_ready=1.
  - wb_eos=1 -> HOLD.
  - wb_valid=0 in WB_STREAM is a protocol error: drive req_valid=0, stay in WB_STREAM; assertion fires in simulation.
- HOLD: exactly one cycle. This covers the registered available flag, which is still high in the cycle after an issue. Next state WAIT_DONE.
- WAIT_DONE: wait for bank_available=1, then go to IDLE. No issue happens in the cycle WAIT_DONE exits; issue resumes the following cycle.
- Minimum spacing between two issued packets is 3 cycles.
- Reads never interrupt a write-back stream. A pe_rd_req dropped before its ack is simply not granted.
- Reset asserted mid-stream: immediate return to IDLE; all outputs 0 asynchronously.

Optional Feature:
- FV_ARB_PERF_CNT_EN defined: adds outputs perf_rd_grants (32b), perf_wb_streams (32b) and perf_stall_cycles (32b).
  - perf_rd_grants counts read issues; perf_wb_streams counts write-back streams issued.
  - perf_stall_cycles counts cycles where a request or wb_valid is pending but nothing issues.
  - All counters saturate at all-ones and reset to 0.
- FV_ARB_PERF_CNT_EN undefined: none of these ports or registers exist.

Decomposition:
- Shared package:
  - arbiter state enum;
  - the request packet struct (the existing Req2Output_SRAM_Bank typedef, reused as-is);
  - NUM_PE/NODE_ID_W/DATA_W derived from `Num_Edge_PE, `Max_Node_id, `FV_bandwidth.
- One sub-module: rr_pick, a combinational round-robin first-set-from-pointer finder (NUM_PE-bit request, pointer in -> one-hot grant, index, found).

Test Plan:
- Reset then pe_rd_req=4'b0101, node ids 0x10/0x30, bank_available=1 -> PE0 issued (tag 0, node 0x10, rd_wr=0). After HOLD and WAIT_DONE, PE2 issued (tag 2, node 0x30). Spacing is at least 3 cycles.
- Write-back of 4 lines (node 0x24, eos on line 4) arrives at the same time as a PE1 read -> the write issues first with 4 consecutive req_valid=1, wr_eos on the 4th. PE1 is issued only after bank_available returns.
- Single-line write-back with wb_eos=1 on the first line -> one packet with wr_eos=1, state goes to HOLD, wb_ready high for exactly 1 cycle.
- bank_available held 0 for 10 cycles with all PEs requesting -> no req_valid. When available rises, grants go in order 0,1,2,3,0 with rr_ptr wrap.
- Assert reset asynchronously during line 2 of a write-back -> req_valid=0 immediately. State is IDLE and rr_ptr=0 after release.
- With FV_ARB_PERF_CNT_EN: 3 reads and 1 write-back with 5 stall cycles -> perf_rd_grants=3, perf_wb_streams=1, perf_stall_cycles=5.
